// File: rtl/alu_result_stage.sv
// Two-entry registered output FIFO behind the bitwise logic unit.
// Status flags are derived once, at capture, and travel with each stored result.
module alu_result_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic             out_all_ones,
    output logic [1:0]       count,
    output logic             err_op
);

    localparam logic [2:0] OP_UNSUPPORTED = 3'b111;

    logic [WIDTH-1:0] res_q [2];
    logic [WIDTH-1:0] res_d [2];
    logic [2:0]       op_q  [2];
    logic [2:0]       op_d  [2];
    logic [3:0]       flg_q [2];
    logic [3:0]       flg_d [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             err_q, err_d;
    logic             accept;
    logic             pop;

    // Packed as {zero, neg, parity, all_ones}.
    function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] r);
        calc_flags = {(r == '0), r[WIDTH-1], ^r, (r == '1)};
    endfunction

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        res_d   = res_q;
        op_d    = op_q;
        flg_d   = flg_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        if (accept) begin
            res_d[tail_q] = in_result;
            op_d[tail_q]  = in_op;
            flg_d[tail_q] = calc_flags(in_result);
            tail_d        = ~tail_q;
            if (in_op == OP_UNSUPPORTED) begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared too, so the head fields read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i] <= '0;
                op_q[i]  <= '0;
                flg_q[i] <= '0;
            end
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            op_q    <= op_d;
            flg_q   <= flg_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign out_result   = res_q[head_q];
    assign out_op       = op_q[head_q];
    assign out_zero     = flg_q[head_q][3];
    assign out_neg      = flg_q[head_q][2];
    assign out_parity   = flg_q[head_q][1];
    assign out_all_ones = flg_q[head_q][0];
    assign count        = count_q;
    assign err_op       = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage (WIDTH = 4).
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [2:0] out_op;
    logic       out_zero;
    logic       out_neg;
    logic       out_parity;
    logic       out_all_ones;
    logic [1:0] count;
    logic       err_op;

    int n_vec  = 0;
    int n_fail = 0;

    alu_result_stage #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_op       (out_op),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .out_parity   (out_parity),
        .out_all_ones (out_all_ones),
        .count        (count),
        .err_op       (err_op)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Fill to two entries, then reset asynchronously mid-cycle.
        in_valid = 1'b1; in_result = 4'h9; in_op = 3'b111; out_ready = 1'b0;
        step();
        in_result = 4'h6; in_op = 3'b001;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (count !== 2'd2) begin n_fail++; $display("FAIL rst_fill count=%0d exp=2", count); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, count, in_ready, err_op} !== 5'b0_00_1_0) begin
            n_fail++;
            $display("FAIL rst_async vld/cnt/rdy/err=%b exp=00010", {out_valid, count, in_ready, err_op});
        end
        n_vec++;
        if ({out_result, out_op, out_zero, out_neg, out_parity, out_all_ones} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_fields got=%h exp=0", {out_result, out_op, out_zero, out_neg, out_parity, out_all_ones});
        end
        step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({out_valid, count, in_ready} !== 4'b0_00_1) begin
            n_fail++;
            $display("FAIL rst_idle vld/cnt/rdy=%b exp=0001", {out_valid, count, in_ready});
        end
    endtask

    task automatic test_single_pass();
        in_valid = 1'b1; in_result = 4'b0000; in_op = 3'b000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, out_result, out_op, out_zero, out_neg, out_parity, out_all_ones, count}
            !== {1'b1, 4'h0, 3'b000, 4'b1000, 2'd1}) begin
            n_fail++;
            $display("FAIL single_head vld=%b res=%h op=%b flg=%b%b%b%b cnt=%0d exp vld=1 res=0 op=000 flg=1000 cnt=1",
                     out_valid, out_result, out_op, out_zero, out_neg, out_parity, out_all_ones, count);
        end
        step();
        n_vec++;
        if ({out_valid, count} !== 3'b0_00) begin
            n_fail++;
            $display("FAIL single_drain vld=%b cnt=%0d exp vld=0 cnt=0", out_valid, count);
        end
    endtask

    task automatic test_flags();
        logic [3:0] res [3];
        logic [2:0] ops [3];
        logic [3:0] flg [3];
        res[0] = 4'b1111; ops[0] = 3'b011; flg[0] = 4'b0101;
        res[1] = 4'b1000; ops[1] = 3'b001; flg[1] = 4'b0110;
        res[2] = 4'b0111; ops[2] = 3'b010; flg[2] = 4'b0010;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_result = res[i]; in_op = ops[i];
            step();
            if (i == 2) in_valid = 1'b0;
            n_vec++;
            if ({out_valid, out_result, out_op, out_zero, out_neg, out_parity, out_all_ones, count}
                !== {1'b1, res[i], ops[i], flg[i], 2'd1}) begin
                n_fail++;
                $display("FAIL flags_%0d res=%b op=%b flg=%b%b%b%b cnt=%0d exp res=%b op=%b flg=%b cnt=1",
                         i, out_result, out_op, out_zero, out_neg, out_parity, out_all_ones, count,
                         res[i], ops[i], flg[i]);
            end
        end
        step();
        n_vec++;
        if (count !== 2'd0) begin n_fail++; $display("FAIL flags_drain cnt=%0d exp=0", count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 4'h1; in_op = 3'b100;
        step();
        in_result = 4'h2;
        step();
        in_result = 4'h3;
        n_vec++;
        if ({count, in_ready, out_result} !== {2'd2, 1'b0, 4'h1}) begin
            n_fail++;
            $display("FAIL bp_full cnt=%0d rdy=%b res=%h exp cnt=2 rdy=0 res=1", count, in_ready, out_result);
        end
        step();
        n_vec++;
        if ({count, in_ready, out_valid, out_result} !== {2'd2, 1'b0, 1'b1, 4'h1}) begin
            n_fail++;
            $display("FAIL bp_hold cnt=%0d rdy=%b vld=%b res=%h exp cnt=2 rdy=0 vld=1 res=1",
                     count, in_ready, out_valid, out_result);
        end
        out_ready = 1'b1;
        step();
        n_vec++;
        if ({count, in_ready, out_result} !== {2'd1, 1'b1, 4'h2}) begin
            n_fail++;
            $display("FAIL bp_pop1 cnt=%0d rdy=%b res=%h exp cnt=1 rdy=1 res=2", count, in_ready, out_result);
        end
        step();
        in_valid = 1'b0;
        n_vec++;
        if ({count, out_valid, out_result} !== {2'd1, 1'b1, 4'h3}) begin
            n_fail++;
            $display("FAIL bp_pop2 cnt=%0d vld=%b res=%h exp cnt=1 vld=1 res=3", count, out_valid, out_result);
        end
        step();
        n_vec++;
        if ({count, out_valid} !== 3'b00_0) begin
            n_fail++;
            $display("FAIL bp_drain cnt=%0d vld=%b exp cnt=0 vld=0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 4'd5; in_op = 3'b101;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_result = 4'(6 + i);
            step();
            n_vec++;
            if ({count, out_result} !== {2'd1, 4'(6 + i)}) begin
                n_fail++;
                $display("FAIL b2b_%0d cnt=%0d res=%0d exp cnt=1 res=%0d", i, count, out_result, 6 + i);
            end
        end
        in_valid = 1'b0;
        step();
        n_vec++;
        if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_drain cnt=%0d exp=0", count); end
    endtask

    task automatic test_err_op();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 4'h0; in_op = 3'b111;
        step();
        n_vec++;
        if ({err_op, out_valid, out_op, out_zero, out_result} !== {1'b1, 1'b1, 3'b111, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL err_set err=%b vld=%b op=%b zero=%b res=%h exp err=1 vld=1 op=111 zero=1 res=0",
                     err_op, out_valid, out_op, out_zero, out_result);
        end
        out_ready = 1'b1; in_result = 4'h3; in_op = 3'b001;
        step();
        in_valid = 1'b0;
        n_vec++;
        if ({err_op, out_op, out_result} !== {1'b1, 3'b001, 4'h3}) begin
            n_fail++;
            $display("FAIL err_sticky err=%b op=%b res=%h exp err=1 op=001 res=3", err_op, out_op, out_result);
        end
        step();
        n_vec++;
        if ({err_op, count} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL err_hold err=%b cnt=%0d exp err=1 cnt=0", err_op, count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (err_op !== 1'b0) begin n_fail++; $display("FAIL err_clear err=%b exp=0", err_op); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_op = '0; out_ready = 1'b0;
        #3;
        n_vec++;
        if ({out_valid, count, in_ready, err_op} !== 5'b0_00_1_0) begin
            n_fail++;
            $display("FAIL init_reset vld/cnt/rdy/err=%b exp=00010", {out_valid, count, in_ready, err_op});
        end
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_single_pass();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_err_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage that sits directly downstream of the bitwise logic unit. It captures each `result`/`op` pair in a 2-entry FIFO with valid/ready handshaking on both sides. At capture it derives status flags (zero, negative, parity, all-ones). It presents results in order to the writeback/consumer stage, decoupling the combinational logic unit from downstream back-pressure.

## Interface
Parameters:
- `WIDTH`, default 4: data width; must match the logic unit width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream presents a logic-unit result.
- `in_ready` output 1: stage can accept; equals (count != 2); no combinational path from `out_ready`.
- `in_result` input WIDTH: logic-unit result.
- `in_op` input 3: op code that produced `in_result` (000=AND … 110=XNOR, 111=unsupported).
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: consumer accepts the head entry.
- `out_result` output WIDTH: head result.
- `out_op` output 3: head op code.
- `out_zero` output 1: head result == 0.
- `out_neg` output 1: head result MSB.
- `out_parity` output 1: XOR-reduction of the head result (1 = odd number of ones).
- `out_all_ones` output 1: head result == all ones.
- `count` output 2: occupancy, 0..2.
- `err_op` output 1: sticky; set when an entry with `in_op` == 111 is accepted.

## Operation
- Storage: 2 entries, each holding {result, op, zero, neg, parity, all_ones}.
- Head/tail pointers are 1 bit each and wrap 1→0.
- Flags are computed from `in_result` at the write and stored; they are never recomputed on the output side.
- Accept = `in_valid` && `in_ready`: write the tail entry, then advance tail.
- Pop = `out_valid` && `out_ready`: advance head.
- Occupancy update per cycle:
  - accept only: count +1.
  - pop only: count −1.
  - both: count unchanged; legal at count 1 (and at count 2 only as a pop, since `in_ready` is 0 when full).
- Full (count 2): `in_ready` = 0; `in_valid` is ignored and no data is lost or overwritten.
- Empty (count 0): `out_valid` = 0 and `out_ready` is ignored.
- Output fields are driven from the head entry. They must hold stable while `out_valid` && !`out_ready`.
- Ordering is strict FIFO; no bypass of the storage.
- `err_op`:
  - Set on accepting op 111; the entry still passes through with its result unchanged (upstream supplies 0).
  - Cleared only by reset.
- Upstream must hold `in_result`/`in_op` stable while `in_valid` && !`in_ready`. The stage does not check this.

## Timing
- Reset (`rst_n` low, asynchronous): count = 0, pointers = 0, `out_valid` = 0, `in_ready` = 1, `err_op` = 0.
  - `out_result`, `out_op` and all flag outputs read 0 during reset (storage cleared).
- Reset mid-operation: all entries are discarded immediately, with no partial pop.
- After `rst_n` rises, the first accept can occur on the next rising edge.
- Latency: accept at edge N into an empty stage gives `out_valid` = 1 after edge N, so the result is available in cycle N+1. No same-cycle passthrough.
- Throughput: 1 entry/cycle sustained when `out_ready` is held high.
- `in_ready` reflects count after the previous edge. Going from full with a pop at edge N makes `in_ready` = 1 in cycle N+1.
- `count` and `err_op` are registered outputs.

## Test plan
- Reset/idle: assert `rst_n` = 0 mid-stream with count 2 → immediately `out_valid` = 0, count = 0, `in_ready` = 1, `err_op` = 0; after release, empty-stage behaviour is clean.
- Single pass, WIDTH=4: accept result 4'b0000 op 000 with `out_ready` = 1 → next cycle `out_result` = 0, `out_zero` = 1, `out_neg` = 0, `out_parity` = 0, `out_all_ones` = 0; count returns to 0 after the pop.
- Flags: stream 4'b1111 (op 011), 4'b1000 (op 001), 4'b0111 (op 010) with `out_ready` = 1:
  - 1111 → all_ones = 1, neg = 1, parity = 0.
  - 1000 → neg = 1, parity = 1.
  - 0111 → parity = 1, neg = 0, zero = 0.
  - Order preserved, one result per cycle.
- Back-pressure/full: `out_ready` = 0, offer 3 results (0x1, 0x2, 0x3) → first two accepted, count = 2, `in_ready` = 0, 0x3 held.
  - Outputs stay 0x1 stable.
  - Raise `out_ready` → sequence 0x1, 0x2, 0x3 with no loss or duplication.
- Simultaneous: at count 1, assert accept and pop in the same cycle, repeated 6 cycles → count stays 1 and pointers wrap correctly.
- Error op: accept `in_op` = 111 with result 0 → `err_op` = 1 the next cycle and stays 1 through later valid ops; the entry exits with `out_op` = 111 and `out_zero` = 1.
